// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller. It sequences memory-wait freezes, mispredict flushes and load-use bubbles.
// It also keeps saturating stall/flush counters and a sticky data-memory timeout flag.
module pipe_hazard_ctrl #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int TIMEOUT_CYCLES   = 64,
    parameter int CNT_W            = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_is_i,
    input  logic [4:0]       rs1_is_i,
    input  logic [4:0]       rs2_is_i,
    input  logic             rs1_used_is_i,
    input  logic             rs2_used_is_i,
    input  logic             valid_ex_i,
    input  logic [4:0]       rd_ex_i,
    input  logic             rf_en_ex_i,
    input  logic [1:0]       wb_sel_ex_i,
    input  logic             brn_mispred_ex_i,
    input  logic             dmem_req_mem_i,
    input  logic             dmem_ack_i,
    output logic             stall_if_o,
    output logic             stall_is_o,
    output logic             stall_ex_o,
    output logic             clr_is_o,
    output logic             clr_ex_o,
    output logic             clr_wb_o,
    output logic             redirect_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             err_timeout_o
);

    typedef enum logic {RUN, LU_STALL} state_e;

    state_e           state_q, state_d;
    logic [1:0]       bub_cnt_q, bub_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             memw, mis, lu, flush_evt;

    assign memw = dmem_req_mem_i & ~dmem_ack_i;
    assign mis  = valid_ex_i & brn_mispred_ex_i;
    assign lu   = valid_ex_i & rf_en_ex_i & (wb_sel_ex_i == 2'b01) & (rd_ex_i != 5'd0) & valid_is_i &
                  ((rs1_used_is_i & (rs1_is_i == rd_ex_i)) | (rs2_used_is_i & (rs2_is_i == rd_ex_i)));

    // A memory wait freezes everything, including the bubble sequence, so a pending hazard replays afterwards.
    always_comb begin
        state_d    = state_q;
        bub_cnt_d  = bub_cnt_q;
        stall_if_o = 1'b0;
        stall_is_o = 1'b0;
        stall_ex_o = 1'b0;
        clr_is_o   = 1'b0;
        clr_ex_o   = 1'b0;
        clr_wb_o   = 1'b0;
        redirect_o = 1'b0;
        flush_evt  = 1'b0;
        if (!reset) begin
            if (memw) begin
                stall_if_o = 1'b1;
                stall_is_o = 1'b1;
                stall_ex_o = 1'b1;
                clr_wb_o   = 1'b1;
            end else begin
                case (state_q)
                    RUN: begin
                        if (mis) begin
                            clr_is_o   = 1'b1;
                            clr_ex_o   = 1'b1;
                            redirect_o = 1'b1;
                            flush_evt  = 1'b1;
                        end else if (lu) begin
                            stall_if_o = 1'b1;
                            stall_is_o = 1'b1;
                            clr_ex_o   = 1'b1;
                            if (LOAD_USE_BUBBLES > 1) begin
                                state_d   = LU_STALL;
                                bub_cnt_d = 2'(LOAD_USE_BUBBLES - 1);
                            end
                        end
                    end
                    LU_STALL: begin
                        stall_if_o = 1'b1;
                        stall_is_o = 1'b1;
                        clr_ex_o   = 1'b1;
                        bub_cnt_d  = bub_cnt_q - 2'd1;
                        if (bub_cnt_q == 2'd1) begin
                            state_d = RUN;
                        end
                    end
                    default: state_d = RUN;
                endcase
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_if_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_evt && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            bub_cnt_q   <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bub_cnt_q   <= bub_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

    // The wait counter saturates at the threshold so that very long waits cannot wrap it.
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
            logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
            logic              err_q, err_d;

            always_comb begin
                wait_cnt_d = '0;
                err_d      = err_q;
                if (memw) begin
                    wait_cnt_d = wait_cnt_q;
                    if (wait_cnt_q != WAIT_W'(TIMEOUT_CYCLES)) begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                    if (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                        err_d = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wait_cnt_q <= '0;
                    err_q      <= 1'b0;
                end else begin
                    wait_cnt_q <= wait_cnt_d;
                    err_q      <= err_d;
                end
            end

            assign err_timeout_o = err_q;
        end else begin : g_no_timeout
            assign err_timeout_o = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. Three instances (1/2/3 bubbles) share one stimulus stream.
// A rule-level model is checked against them every cycle, alongside hand-computed expectations.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       validIs;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1Used;
        logic       rs2Used;
        logic       validEx;
        logic [4:0] rdEx;
        logic       rfEnEx;
        logic [1:0] wbSelEx;
        logic       mis;
        logic       dmemReq;
        logic       dmemAck;
    } stim_t;

    localparam logic [6:0] CTL_BUBBLE = 7'b1100100;
    localparam logic [6:0] CTL_FLUSH  = 7'b0001101;
    localparam logic [6:0] CTL_FREEZE = 7'b1110010;

    logic       clk = 1'b0;
    logic       reset;
    logic       validIs, rs1Used, rs2Used, validEx, rfEnEx, brnMis, dmemReq, dmemAck;
    logic [4:0] rs1Is, rs2Is, rdEx;
    logic [1:0] wbSelEx;

    logic       stallIf [3];
    logic       stallIs [3];
    logic       stallEx [3];
    logic       clrIs [3];
    logic       clrEx [3];
    logic       clrWb [3];
    logic       redirect [3];
    logic       errTo [3];
    logic [2:0] stallCnt1, flushCnt1;
    logic [31:0] stallCnt2, flushCnt2, stallCnt3, flushCnt3;
    logic [6:0]  ctl [3];
    logic [31:0] scA [3];
    logic [31:0] fcA [3];

    int total = 0;
    int bad   = 0;

    // Model state per instance: bubbles still owed, memw run length, counters, sticky error.
    int     lubP [3] = '{1, 2, 3};
    int     tmoP [3] = '{4, 64, 0};
    int     cwP  [3] = '{3, 32, 32};
    int     bubLeft [3];
    int     waitRun [3];
    longint mStall [3];
    longint mFlush [3];
    bit     mErr [3];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LOAD_USE_BUBBLES(1), .TIMEOUT_CYCLES(4), .CNT_W(3)) dut1 (
        .clk(clk), .reset(reset), .valid_is_i(validIs), .rs1_is_i(rs1Is), .rs2_is_i(rs2Is),
        .rs1_used_is_i(rs1Used), .rs2_used_is_i(rs2Used), .valid_ex_i(validEx), .rd_ex_i(rdEx),
        .rf_en_ex_i(rfEnEx), .wb_sel_ex_i(wbSelEx), .brn_mispred_ex_i(brnMis),
        .dmem_req_mem_i(dmemReq), .dmem_ack_i(dmemAck),
        .stall_if_o(stallIf[0]), .stall_is_o(stallIs[0]), .stall_ex_o(stallEx[0]),
        .clr_is_o(clrIs[0]), .clr_ex_o(clrEx[0]), .clr_wb_o(clrWb[0]), .redirect_o(redirect[0]),
        .stall_cnt_o(stallCnt1), .flush_cnt_o(flushCnt1), .err_timeout_o(errTo[0]));

    pipe_hazard_ctrl #(.LOAD_USE_BUBBLES(2), .TIMEOUT_CYCLES(64), .CNT_W(32)) dut2 (
        .clk(clk), .reset(reset), .valid_is_i(validIs), .rs1_is_i(rs1Is), .rs2_is_i(rs2Is),
        .rs1_used_is_i(rs1Used), .rs2_used_is_i(rs2Used), .valid_ex_i(validEx), .rd_ex_i(rdEx),
        .rf_en_ex_i(rfEnEx), .wb_sel_ex_i(wbSelEx), .brn_mispred_ex_i(brnMis),
        .dmem_req_mem_i(dmemReq), .dmem_ack_i(dmemAck),
        .stall_if_o(stallIf[1]), .stall_is_o(stallIs[1]), .stall_ex_o(stallEx[1]),
        .clr_is_o(clrIs[1]), .clr_ex_o(clrEx[1]), .clr_wb_o(clrWb[1]), .redirect_o(redirect[1]),
        .stall_cnt_o(stallCnt2), .flush_cnt_o(flushCnt2), .err_timeout_o(errTo[1]));

    pipe_hazard_ctrl #(.LOAD_USE_BUBBLES(3), .TIMEOUT_CYCLES(0), .CNT_W(32)) dut3 (
        .clk(clk), .reset(reset), .valid_is_i(validIs), .rs1_is_i(rs1Is), .rs2_is_i(rs2Is),
        .rs1_used_is_i(rs1Used), .rs2_used_is_i(rs2Used), .valid_ex_i(validEx), .rd_ex_i(rdEx),
        .rf_en_ex_i(rfEnEx), .wb_sel_ex_i(wbSelEx), .brn_mispred_ex_i(brnMis),
        .dmem_req_mem_i(dmemReq), .dmem_ack_i(dmemAck),
        .stall_if_o(stallIf[2]), .stall_is_o(stallIs[2]), .stall_ex_o(stallEx[2]),
        .clr_is_o(clrIs[2]), .clr_ex_o(clrEx[2]), .clr_wb_o(clrWb[2]), .redirect_o(redirect[2]),
        .stall_cnt_o(stallCnt3), .flush_cnt_o(flushCnt3), .err_timeout_o(errTo[2]));

    for (genvar g = 0; g < 3; g++) begin : g_pack
        assign ctl[g] = {stallIf[g], stallIs[g], stallEx[g], clrIs[g], clrEx[g], clrWb[g], redirect[g]};
    end
    assign scA[0] = {29'd0, stallCnt1};
    assign fcA[0] = {29'd0, flushCnt1};
    assign scA[1] = stallCnt2;
    assign fcA[1] = flushCnt2;
    assign scA[2] = stallCnt3;
    assign fcA[2] = flushCnt3;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    function automatic stim_t idleStim();
        return '0;
    endfunction

    function automatic stim_t luStim(input logic [4:0] rd, input logic misB);
        stim_t s;
        s = '0;
        s.validIs = 1'b1;
        s.rs1     = rd;
        s.rs2     = 5'd7;
        s.rs1Used = 1'b1;
        s.rs2Used = 1'b1;
        s.validEx = 1'b1;
        s.rdEx    = rd;
        s.rfEnEx  = 1'b1;
        s.wbSelEx = 2'b01;
        s.mis     = misB;
        return s;
    endfunction

    function automatic stim_t memStim(input logic ack);
        stim_t s;
        s = '0;
        s.dmemReq = 1'b1;
        s.dmemAck = ack;
        return s;
    endfunction

    task automatic driveInputs(input stim_t s);
        validIs = s.validIs;
        rs1Is   = s.rs1;
        rs2Is   = s.rs2;
        rs1Used = s.rs1Used;
        rs2Used = s.rs2Used;
        validEx = s.validEx;
        rdEx    = s.rdEx;
        rfEnEx  = s.rfEnEx;
        wbSelEx = s.wbSelEx;
        brnMis  = s.mis;
        dmemReq = s.dmemReq;
        dmemAck = s.dmemAck;
    endtask

    task automatic applyStimulus(input stim_t s);
        @(posedge clk);
        #1;
        driveInputs(s);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        driveInputs(idleStim());
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Every falling edge: derive expected outputs from the hazard rules, compare, then advance the model.
    always @(negedge clk) begin
        logic memwM, misM, luM;
        memwM = dmemReq & ~dmemAck;
        misM  = validEx & brnMis;
        luM   = validEx & rfEnEx & (wbSelEx == 2'b01) & (rdEx != 5'd0) & validIs &
                ((rs1Used & (rs1Is == rdEx)) | (rs2Used & (rs2Is == rdEx)));
        for (int i = 0; i < 3; i++) begin
            logic [6:0] expCtl;
            bit         doFlush;
            longint     maxCnt;
            maxCnt  = (longint'(1) << cwP[i]) - 1;
            expCtl  = '0;
            doFlush = 1'b0;
            if (reset) begin
                bubLeft[i] = 0;
                waitRun[i] = 0;
                mStall[i]  = 0;
                mFlush[i]  = 0;
                mErr[i]    = 1'b0;
            end else if (memwM) begin
                expCtl = CTL_FREEZE;
            end else if (bubLeft[i] > 0) begin
                expCtl     = CTL_BUBBLE;
                bubLeft[i] = bubLeft[i] - 1;
            end else if (misM) begin
                expCtl  = CTL_FLUSH;
                doFlush = 1'b1;
            end else if (luM) begin
                expCtl     = CTL_BUBBLE;
                bubLeft[i] = lubP[i] - 1;
            end
            checkOutput($sformatf("model ctl dut%0d", i + 1), ctl[i], expCtl);
            checkOutput($sformatf("model stall_cnt dut%0d", i + 1), scA[i], mStall[i]);
            checkOutput($sformatf("model flush_cnt dut%0d", i + 1), fcA[i], mFlush[i]);
            checkOutput($sformatf("model err dut%0d", i + 1), errTo[i], mErr[i]);
            if (!reset) begin
                if (expCtl[6] && mStall[i] < maxCnt) mStall[i] = mStall[i] + 1;
                if (doFlush && mFlush[i] < maxCnt) mFlush[i] = mFlush[i] + 1;
                waitRun[i] = memwM ? waitRun[i] + 1 : 0;
                if (tmoP[i] != 0 && waitRun[i] >= tmoP[i]) mErr[i] = 1'b1;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        driveInputs(idleStim());
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Load-use: 1, 2 and 3 bubbles on the three instances from a single hazard cycle.
        applyStimulus(luStim(5'd5, 1'b0));
        #2;
        checkOutput("lu bubble dut1", ctl[0], CTL_BUBBLE);
        checkOutput("lu bubble dut3", ctl[2], CTL_BUBBLE);
        applyStimulus(idleStim());
        #2;
        checkOutput("lu done ctl dut1", ctl[0], 7'b0);
        checkOutput("lu stall_cnt dut1", scA[0], 1);
        checkOutput("lu 2nd bubble dut3", ctl[2], CTL_BUBBLE);
        applyStimulus(idleStim());
        #2;
        checkOutput("lu done ctl dut2", ctl[1], 7'b0);
        checkOutput("lu stall_cnt dut2", scA[1], 2);
        checkOutput("lu 3rd bubble dut3", ctl[2], CTL_BUBBLE);
        applyStimulus(idleStim());
        #2;
        checkOutput("lu done ctl dut3", ctl[2], 7'b0);
        checkOutput("lu stall_cnt dut3", scA[2], 3);

        // rd_ex = x0 never interlocks.
        applyStimulus(luStim(5'd0, 1'b0));
        #2;
        checkOutput("rd0 no stall dut3", ctl[2], 7'b0);

        // Mispredict wins over a simultaneous load-use hazard.
        applyStimulus(luStim(5'd5, 1'b1));
        #2;
        checkOutput("mis flush dut1", ctl[0], CTL_FLUSH);
        checkOutput("mis flush dut3", ctl[2], CTL_FLUSH);
        applyStimulus(idleStim());
        #2;
        checkOutput("mis after ctl dut3", ctl[2], 7'b0);
        checkOutput("mis flush_cnt dut1", fcA[0], 1);

        // Memory wait in the middle of a 2-bubble load-use sequence.
        doReset();
        applyStimulus(luStim(5'd5, 1'b0));
        for (int k = 0; k < 4; k++) begin
            applyStimulus(memStim(1'b0));
            #2;
            checkOutput("memw freeze dut2", ctl[1], CTL_FREEZE);
        end
        applyStimulus(memStim(1'b1));
        #2;
        checkOutput("memw resumed bubble dut2", ctl[1], CTL_BUBBLE);
        applyStimulus(idleStim());
        #2;
        checkOutput("memw done ctl dut2", ctl[1], 7'b0);
        checkOutput("memw stall_cnt dut2", scA[1], 6);
        repeat (2) applyStimulus(idleStim());

        // Timeout: 3 waits stay clear, 4 waits set the sticky flag.
        doReset();
        repeat (3) applyStimulus(memStim(1'b0));
        applyStimulus(idleStim());
        #2;
        checkOutput("timeout 3 waits dut1", errTo[0], 0);
        repeat (4) applyStimulus(memStim(1'b0));
        #2;
        checkOutput("timeout before 4th edge dut1", errTo[0], 0);
        applyStimulus(memStim(1'b1));
        #2;
        checkOutput("timeout set dut1", errTo[0], 1);
        applyStimulus(idleStim());
        #2;
        checkOutput("timeout sticky dut1", errTo[0], 1);
        checkOutput("timeout disabled dut3", errTo[2], 0);

        // Async reset in the middle of a bubble sequence with stall_cnt at 5.
        doReset();
        applyStimulus(luStim(5'd5, 1'b0));
        applyStimulus(idleStim());
        applyStimulus(idleStim());
        applyStimulus(luStim(5'd5, 1'b0));
        applyStimulus(idleStim());
        applyStimulus(idleStim());
        #1;
        checkOutput("pre-reset bubble dut3", ctl[2], CTL_BUBBLE);
        checkOutput("pre-reset stall_cnt dut3", scA[2], 5);
        reset = 1'b1;
        #1;
        checkOutput("async reset ctl dut3", ctl[2], 7'b0);
        checkOutput("async reset stall_cnt dut3", scA[2], 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(idleStim());
        #2;
        checkOutput("run after reset dut3", ctl[2], 7'b0);

        // Saturation of the 3-bit counters on dut1.
        doReset();
        repeat (9) applyStimulus(luStim(5'd5, 1'b0));
        repeat (3) applyStimulus(idleStim());
        #2;
        checkOutput("stall_cnt saturated dut1", scA[0], 7);
        repeat (9) applyStimulus(luStim(5'd5, 1'b1));
        applyStimulus(idleStim());
        #2;
        checkOutput("flush_cnt saturated dut1", fcA[0], 7);
        applyStimulus(luStim(5'd5, 1'b0));
        applyStimulus(idleStim());
        #2;
        checkOutput("stall_cnt holds dut1", scA[0], 7);
        @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage RISC-V pipeline. It sequences the fetch, issue, execute and writeback pipeline registers through three mechanisms: load-use interlock bubbles, branch/jump mispredict flushes and data-memory wait freezes. It drives the clr input of the issue-execute register and the hold/clear controls of the neighbouring stages. It also keeps saturating stall/flush performance counters and a sticky memory-timeout error.

Parameters:
LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (1..3; 1 = MEM->EX forwarding present)
TIMEOUT_CYCLES, 64, consecutive dmem wait cycles before err_timeout_o sets; 0 disables
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
valid_is_i  in  1  issue-stage instruction valid
rs1_is_i  in  5  issue-stage rs1
rs2_is_i  in  5  issue-stage rs2
rs1_used_is_i  in  1  issue instr reads rs1
rs2_used_is_i  in  1  issue instr reads rs2
valid_ex_i  in  1  valid_ex_pipe_reg_o
rd_ex_i  in  5  rd_ex_pipe_reg_o
rf_en_ex_i  in  1  rf_en_ex_pipe_reg_o
wb_sel_ex_i  in  2  wb_sel_ex_pipe_reg_o; 2'b01 = load data
brn_mispred_ex_i  in  1  EX resolved branch/jump target != next_pred_pc
dmem_req_mem_i  in  1  MEM stage has an outstanding data access
dmem_ack_i  in  1  data memory completes access this cycle
stall_if_o  out  1  hold PC/fetch register
stall_is_o  out  1  hold issue pipe register
stall_ex_o  out  1  hold ex pipe register
clr_is_o  out  1  clear issue pipe register
clr_ex_o  out  1  clear ex pipe register (to clr)
clr_wb_o  out  1  insert bubble into WB register
redirect_o  out  1  fetch takes EX-resolved PC this cycle
stall_cnt_o  out  CNT_W  cycles with stall_if_o=1, saturating
flush_cnt_o  out  CNT_W  mispredict flushes, saturating
err_timeout_o  out  1  sticky memory-timeout flag

Behaviour:
- Conditions (combinational):
  - memw = dmem_req_mem_i & ~dmem_ack_i
  - mis = valid_ex_i & brn_mispred_ex_i
  - lu = valid_ex_i & rf_en_ex_i & wb_sel_ex_i==2'b01 & rd_ex_i!=0 & valid_is_i & ((rs1_used_is_i & rs1_is_i==rd_ex_i) | (rs2_used_is_i & rs2_is_i==rd_ex_i))
- States: RUN, LU_STALL. The bubble counter bub_cnt is 2 bits.
- Outputs are Mealy (same cycle). Priority is memw > mis > lu.
- memw, any state:
  - stall_if, stall_is and stall_ex = 1; clr_wb = 1; all other outputs 0.
  - State and bub_cnt frozen.
  - A pending mis or lu is applied in the first cycle after memw drops; EX is held, so its inputs remain valid.
- RUN & mis:
  - clr_is = clr_ex = redirect = 1; stalls 0.
  - flush_cnt +1.
  - Wins over a simultaneous lu, because the issue instruction is squashed.
- RUN & lu (no mis):
  - stall_if = stall_is = clr_ex = 1.
  - If LOAD_USE_BUBBLES > 1: next state LU_STALL, bub_cnt <= LOAD_USE_BUBBLES-1.
- LU_STALL (no memw):
  - stall_if = stall_is = clr_ex = 1; bub_cnt decrements.
  - When bub_cnt==1, next state RUN.
  - mis cannot occur here, because EX holds a bubble.
- Otherwise all outputs 0.
- stall_cnt:
  - Increments on every cycle with stall_if_o=1.
  - Both counters hold at all-ones.
- Timeout:
  - wait_cnt counts consecutive memw cycles and clears when memw=0.
  - err_timeout_o sets on the edge ending the TIMEOUT_CYCLES-th consecutive memw cycle.
  - It stays set until reset.
- Reset (async, any state):
  - State RUN, bub_cnt 0, wait_cnt 0, counters 0, err_timeout_o 0.
  - While reset is high, every combinational output is forced to 0; the pipe registers self-reset.
- Latency: zero-cycle response to all hazards; exactly LOAD_USE_BUBBLES bubbles per load-use event, excluding memw freeze cycles.

Test Plan:
- Load-use, param 1: EX lw x5 (rd=5, wb_sel=01), issue add x6,x5,x7 with rs1_used=1 -> one cycle stall_if=stall_is=clr_ex=1, then all 0; stall_cnt=1.
- Load-use, param 3: same stimulus -> 3 consecutive bubble cycles, state returns to RUN; rd_ex=0 variant -> no stall.
- Mispredict: mis=1 together with a load-use hazard -> clr_is=clr_ex=redirect=1 for one cycle, no stall, flush_cnt=1.
- Memory wait during LU_STALL, param 2: dmem_req=1, ack=0 for 4 cycles -> stall_ex=clr_wb=1, bub_cnt frozen; after ack the remaining bubble is issued; stall_cnt=6.
- Timeout with TIMEOUT_CYCLES=4: memw for 4 cycles -> err_timeout_o=1 after the 4th edge and stays set after ack; memw for 3 cycles -> stays 0.
- Async reset asserted mid LU_STALL with counters at 5 -> all outputs 0 immediately, counters 0, RUN after deassertion; a saturation check forces counters to all-ones and confirms they hold.
